miner_work_io: RTL

MINER_WORK_IO -- requirements
Module: miner_work_io

---
 rtl/miner_io_pkg.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/miner_work_io.sv | 115 +++++++++++
 3 files changed

// File: rtl/miner_io_pkg.sv
// Shared types and default sizing for the miner work/result I/O block.
package miner_io_pkg;

    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_NUM_WORDS  = 11;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head is always the oldest entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A pop frees a slot in the same cycle, so a push to a full FIFO is accepted alongside it
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/miner_work_io.sv
// Serial work-frame loader and golden-nonce result queue for a hashing core.
module miner_work_io
    import miner_io_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ready,
    input  logic [WORD_W-1:0]           serial_in,
    output logic [NUM_WORDS*WORD_W-1:0] work_data,
    output logic                        work_valid,
    output logic                        load_busy,
    input  logic                        core_hit,
    input  logic [WORD_W-1:0]           core_nonce,
    input  logic                        result_ack,
    output logic                        hit,
    output logic [WORD_W-1:0]           serial_out,
    output logic                        overflow
);

    localparam int unsigned CNT_W   = $clog2(NUM_WORDS + 1);
    localparam int unsigned FRAME_W = NUM_WORDS * WORD_W;

    load_state_e        r_state;
    logic [CNT_W-1:0]   r_count;
    logic [FRAME_W-1:0] r_shadow;
    logic [FRAME_W-1:0] r_work_data;
    logic               r_work_valid;
    logic               r_overflow;

    logic [CNT_W-1:0]   w_idx;
    logic               w_last;
    logic [FRAME_W-1:0] w_frame;
    logic               w_full;
    logic               w_empty;

    // Slot index of the word on serial_in this cycle; IDLE always starts a new frame
    assign w_idx  = (r_state == IDLE) ? '0 : r_count;
    assign w_last = (w_idx == CNT_W'(NUM_WORDS - 1));

    // Shadow frame with the current word merged in; word 0 lands in the MS slot
    always_comb begin
        w_frame = r_shadow;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (w_idx == CNT_W'(k)) begin
                w_frame[(NUM_WORDS-1-k)*WORD_W +: WORD_W] = serial_in;
            end
        end
    end

    // Loader FSM: accumulate into the shadow, publish to work_data only on the last word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_shadow     <= '0;
            r_work_data  <= '0;
            r_work_valid <= 1'b0;
        end else begin
            r_work_valid <= 1'b0;
            if (ready) begin
                if (w_last) begin
                    r_work_data  <= w_frame;
                    r_work_valid <= 1'b1;
                    r_shadow     <= '0;
                    r_state      <= IDLE;
                    r_count      <= '0;
                end else begin
                    r_shadow <= w_frame;
                    r_state  <= LOAD;
                    r_count  <= CNT_W'(w_idx + CNT_W'(1));
                end
            end else begin
                if (r_state == LOAD) begin
                    r_shadow <= '0;
                end
                r_state <= IDLE;
                r_count <= '0;
            end
        end
    end

    // Sticky flag for a nonce lost to a full queue with no simultaneous pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (core_hit && w_full && !result_ack) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (core_hit),
        .i_data  (core_nonce),
        .i_pop   (result_ack),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (serial_out)
    );

    assign work_data  = r_work_data;
    assign work_valid = r_work_valid;
    assign load_busy  = (r_state == LOAD);
    assign hit        = !w_empty;
    assign overflow   = r_overflow;

endmodule
